ori_hist_accum: RTL and testbench

Accumulates gradient-magnitude-weighted orientation samples into a 32-bin histogram for one keypoint window, then finds the dominant orientation bin. It sits directly downstream of the direction-bin ROM, which supplies the 5-bit `in_dir`, and of the gradient-magnitude path, which supplies `in_mag`. Its result feeds the descriptor stage's rotation selection.

---
 rtl/ori_hist_accum_pkg.sv | 16 +
 rtl/ori_hist_peak.sv | 55 +++++
 rtl/ori_hist_accum.sv | 137 +++++++++++++
 tb/tb_ori_hist_accum.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ori_hist_accum_pkg.sv
// Shared definitions for the orientation histogram block and the direction ROM.
//   ORI_BINS / ORI_BIN_W : histogram size and bin index width
//   ori_state_e          : accumulator control states
package ori_hist_accum_pkg;

    localparam int unsigned ORI_BINS  = 32;
    localparam int unsigned ORI_BIN_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SCAN  = 2'd2,
        DONE  = 2'd3
    } ori_state_e;

endpackage : ori_hist_accum_pkg

// File: rtl/ori_hist_peak.sv
// Scan datapath: circular 1-2-1 smoothing of one bin per cycle plus the running
// max/argmax. The max is replaced only on a strictly greater value, so ties keep
// the lower index. Index 0 always seeds the running max.
//   clk, rst_n          : clock, async active-low reset
//   scan_en             : a bin is being scanned this cycle
//   idx                 : bin index being scanned
//   left/center/right   : bin[idx-1], bin[idx], bin[idx+1] (circular)
//   best_bin_c/_val_c   : running max including the current bin (combinational)
module ori_hist_peak
    import ori_hist_accum_pkg::*;
#(
    parameter int unsigned ACC_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 scan_en,
    input  logic [ORI_BIN_W-1:0] idx,
    input  logic [ACC_W-1:0]     left,
    input  logic [ACC_W-1:0]     center,
    input  logic [ACC_W-1:0]     right,
    output logic [ORI_BIN_W-1:0] best_bin_c,
    output logic [ACC_W+1:0]     best_val_c
);

    localparam int unsigned SUM_W = ACC_W + 2;

    logic [SUM_W-1:0]     smooth_c;
    logic [SUM_W-1:0]     best_val_q;
    logic [ORI_BIN_W-1:0] best_bin_q;

    // Sum of four ACC_W values fits in ACC_W+2 bits, so no overflow.
    assign smooth_c = SUM_W'(left) + SUM_W'(right) + SUM_W'({center, 1'b0});

    // Candidate update: seed on index 0, else strictly-greater replacement.
    always_comb begin
        best_bin_c = best_bin_q;
        best_val_c = best_val_q;
        if ((idx == '0) || (smooth_c > best_val_q)) begin
            best_bin_c = idx;
            best_val_c = smooth_c;
        end
    end

    // Running max register, advanced only while scanning.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_bin_q <= '0;
            best_val_q <= '0;
        end else if (scan_en) begin
            best_bin_q <= best_bin_c;
            best_val_q <= best_val_c;
        end
    end

endmodule : ori_hist_peak

// File: rtl/ori_hist_accum.sv
// Magnitude-weighted orientation histogram for one keypoint window, followed by
// a 32-cycle scan for the dominant (smoothed) bin.
//   clk, rst_n        : clock, async active-low reset
//   start             : open a new window (IDLE only)
//   in_valid/in_ready : sample handshake; in_ready high only in ACCUM
//   in_dir, in_mag    : bin index and weight of a sample
//   in_last           : final sample of the window
//   busy              : block not in IDLE
//   done              : one-cycle pulse, peak outputs valid from this cycle
//   peak_bin/peak_val : dominant bin and its smoothed value
module ori_hist_accum
    import ori_hist_accum_pkg::*;
#(
    parameter int unsigned MAG_W = 8,
    parameter int unsigned ACC_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ORI_BIN_W-1:0] in_dir,
    input  logic [MAG_W-1:0]     in_mag,
    input  logic                 in_last,
    output logic                 busy,
    output logic                 done,
    output logic [ORI_BIN_W-1:0] peak_bin,
    output logic [ACC_W+1:0]     peak_val
);

    localparam int unsigned ACC1_W = ACC_W + 1;
    localparam logic [ORI_BIN_W-1:0] IDX_ONE  = ORI_BIN_W'(1);
    localparam logic [ORI_BIN_W-1:0] IDX_LAST = ORI_BIN_W'(ORI_BINS - 1);

    ori_state_e           state_q;
    ori_state_e           state_d;
    logic [ORI_BIN_W-1:0] idx_q;
    logic [ACC_W-1:0]     bins_q [ORI_BINS];

    logic                 beat_c;
    logic                 scan_c;
    logic                 scan_last_c;
    logic [ACC1_W-1:0]    acc_sum_c;
    logic [ACC_W-1:0]     acc_sat_c;
    logic [ORI_BIN_W-1:0] idx_left_c;
    logic [ORI_BIN_W-1:0] idx_right_c;
    logic [ORI_BIN_W-1:0] best_bin_c;
    logic [ACC_W+1:0]     best_val_c;

    // Handshake and status are pure decodes of the state register.
    assign in_ready    = (state_q == ACCUM);
    assign busy        = (state_q != IDLE);
    assign beat_c      = in_valid & in_ready;
    assign scan_c      = (state_q == SCAN);
    assign scan_last_c = scan_c && (idx_q == IDX_LAST);

    // Saturating accumulate into the addressed bin.
    assign acc_sum_c = ACC1_W'(bins_q[in_dir]) + ACC1_W'(in_mag);
    assign acc_sat_c = acc_sum_c[ACC_W] ? {ACC_W{1'b1}} : acc_sum_c[ACC_W-1:0];

    // Circular neighbours fall out of 5-bit wraparound arithmetic.
    assign idx_left_c  = idx_q - IDX_ONE;
    assign idx_right_c = idx_q + IDX_ONE;

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ACCUM;
            ACCUM:   if (beat_c && in_last) state_d = SCAN;
            SCAN:    if (scan_last_c) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Scan index: walks 0..31 during SCAN, parked at 0 otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else if (scan_c) begin
            idx_q <= idx_q + IDX_ONE;
        end else begin
            idx_q <= '0;
        end
    end

    // Bin register file: cleared on reset and on window start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bins_q <= '{default: '0};
        end else if ((state_q == IDLE) && start) begin
            bins_q <= '{default: '0};
        end else if (beat_c) begin
            bins_q[in_dir] <= acc_sat_c;
        end
    end

    ori_hist_peak #(
        .ACC_W (ACC_W)
    ) u_peak (
        .clk        (clk),
        .rst_n      (rst_n),
        .scan_en    (scan_c),
        .idx        (idx_q),
        .left       (bins_q[idx_left_c]),
        .center     (bins_q[idx_q]),
        .right      (bins_q[idx_right_c]),
        .best_bin_c (best_bin_c),
        .best_val_c (best_val_c)
    );

    // Result capture on the final scan cycle, so done and peak land in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done     <= 1'b0;
            peak_bin <= '0;
            peak_val <= '0;
        end else begin
            done <= scan_last_c;
            if (scan_last_c) begin
                peak_bin <= best_bin_c;
                peak_val <= best_val_c;
            end
        end
    end

endmodule : ori_hist_accum

// File: tb/tb_ori_hist_accum.sv
// Bench for ori_hist_accum: table of windows with constant expected peaks,
// a scoreboard popped on every done pulse, and hand-written corner sequences.
module tb_ori_hist_accum;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_dir;
    logic [7:0]  in_mag;
    logic        in_last;
    logic        busy;
    logic        done;
    logic [4:0]  peak_bin;
    logic [17:0] peak_val;

    ori_hist_accum #(.MAG_W(8), .ACC_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_dir   (in_dir),
        .in_mag   (in_mag),
        .in_last  (in_last),
        .busy     (busy),
        .done     (done),
        .peak_bin (peak_bin),
        .peak_val (peak_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int dir1; int mag1; int n1;
        int dir2; int mag2; int n2;
        int exp_bin; int exp_val;
    } vec_t;

    typedef struct {
        int bin;
        int val;
    } exp_t;

    int   n_vec = 0;
    int   n_err = 0;
    int   done_cnt = 0;
    exp_t sb_q[$];
    int   q_dir[$];
    int   q_mag[$];
    int   model_bins[32];

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Scoreboard: each done pulse consumes one expected result.
    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            done_cnt++;
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got done=1, expected no pending result (t=%0t)", $time);
            end else begin
                e = sb_q.pop_front();
                check("sb_peak_bin", int'(peak_bin), e.bin);
                check("sb_peak_val", int'(peak_val), e.val);
            end
        end
    end

    // Opens a window, plays q_dir/q_mag, and checks scan/done timing.
    task automatic do_window(input bit gaps, input bit hold_start);
        int k;
        int n;
        bit ready_seen;
        n = q_dir.size();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1;
        if (!hold_start) start = 1'b0;
        check("in_ready_in_accum", int'(in_ready), 1);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) begin
                    in_valid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            in_valid = 1'b1;
            in_dir   = 5'(q_dir[i]);
            in_mag   = 8'(q_mag[i]);
            in_last  = (i == n - 1);
            @(posedge clk); #1;
        end
        in_valid   = 1'b0;
        in_last    = 1'b0;
        ready_seen = 1'b0;
        // Last beat accepted at edge L; done expected after the 32nd later edge.
        for (k = 1; k <= 40; k++) begin
            if (in_ready) ready_seen = 1'b1;
            @(posedge clk); #1;
            if (done) break;
        end
        if (hold_start) start = 1'b0;
        check("done_latency", k, 32);
        check("in_ready_low_in_scan", int'(ready_seen), 0);
        check("busy_in_done", int'(busy), 1);
        @(posedge clk); #1;
        check("busy_after_done", int'(busy), 0);
        check("done_one_cycle", int'(done), 0);
    endtask

    task automatic load_beats(input int dir, input int mag, input int n);
        for (int i = 0; i < n; i++) begin
            q_dir.push_back(dir);
            q_mag.push_back(mag);
        end
    endtask

    task automatic model_expect(output int pb, output int pv);
        int s;
        pb = 0;
        pv = 0;
        for (int i = 0; i < 32; i++) begin
            s = model_bins[(i + 31) % 32] + 2 * model_bins[i] + model_bins[(i + 1) % 32];
            if (i == 0 || s > pv) begin
                pb = i;
                pv = s;
            end
        end
    endtask

    vec_t vecs[6];

    initial begin
        exp_t e;
        int   cnt0;
        int   pb;
        int   pv;

        vecs[0] = '{7, 100, 1,    0, 0, 0,     7, 200};
        vecs[1] = '{31, 50, 1,    0, 50, 1,    0, 150};
        vecs[2] = '{3, 255, 300,  0, 0, 0,     3, 131070};
        vecs[3] = '{9, 0, 1,      0, 0, 0,     0, 0};
        vecs[4] = '{5, 10, 3,     6, 20, 1,    5, 80};
        vecs[5] = '{20, 200, 2,   22, 200, 2,  20, 800};

        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_dir   = '0;
        in_mag   = '0;
        in_last  = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_done", int'(done), 0);
        check("rst_peak_bin", int'(peak_bin), 0);
        check("rst_peak_val", int'(peak_val), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven windows.
        for (int v = 0; v < 6; v++) begin
            q_dir.delete();
            q_mag.delete();
            load_beats(vecs[v].dir1, vecs[v].mag1, vecs[v].n1);
            load_beats(vecs[v].dir2, vecs[v].mag2, vecs[v].n2);
            e.bin = vecs[v].exp_bin;
            e.val = vecs[v].exp_val;
            sb_q.push_back(e);
            do_window(1'b0, 1'b0);
        end

        // Peak outputs hold while idle.
        repeat (10) @(posedge clk);
        #1;
        check("idle_hold_bin", int'(peak_bin), 20);
        check("idle_hold_val", int'(peak_val), 800);

        // Start held high through ACCUM and SCAN: one window, one done.
        q_dir.delete();
        q_mag.delete();
        load_beats(1, 4, 1);
        e.bin = 1;
        e.val = 8;
        sb_q.push_back(e);
        cnt0 = done_cnt;
        do_window(1'b0, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        check("held_start_one_done", done_cnt - cnt0, 1);
        check("held_start_no_restart", int'(busy), 0);

        // Random valid gaps, 20 beats, reference-model expectation.
        q_dir.delete();
        q_mag.delete();
        for (int i = 0; i < 32; i++) model_bins[i] = 0;
        for (int i = 0; i < 20; i++) begin
            int d;
            int m;
            d = int'($urandom_range(0, 31));
            m = int'($urandom_range(0, 255));
            q_dir.push_back(d);
            q_mag.push_back(m);
            model_bins[d] = (model_bins[d] + m > 65535) ? 65535 : model_bins[d] + m;
        end
        model_expect(pb, pv);
        e.bin = pb;
        e.val = pv;
        sb_q.push_back(e);
        do_window(1'b1, 1'b0);

        // Reset mid-ACCUM discards the partial window and zeroes outputs.
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        in_valid = 1'b1;
        in_dir   = 5'd12;
        in_mag   = 8'd200;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("abort_busy", int'(busy), 0);
        check("abort_in_ready", int'(in_ready), 0);
        check("abort_peak_bin", int'(peak_bin), 0);
        check("abort_peak_val", int'(peak_val), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        q_dir.delete();
        q_mag.delete();
        load_beats(12, 10, 1);
        e.bin = 12;
        e.val = 20;
        sb_q.push_back(e);
        do_window(1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_ori_hist_accum
